// File: rtl/timer_min_sec_ctrl_pkg.sv
// rtl/timer_min_sec_ctrl_pkg.sv - shared state encoding and limits for the min:sec timer
package timer_min_sec_ctrl_pkg;

  localparam int VAL_W       = 6;
  localparam int MAX_MIN_DEF = 59;
  localparam int MAX_SEC_DEF = 59;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/timer_tick_gen.sv
// rtl/timer_tick_gen.sv - enable-gated 1-second prescaler with synchronous clear
module timer_tick_gen #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count holds while en is low, so a paused timer resumes mid-second.
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_min_sec_ctrl.sv
// rtl/timer_min_sec_ctrl.sv - countdown timer FSM owning the min/sec registers and prescaler
module timer_min_sec_ctrl
  import timer_min_sec_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int MAX_MIN  = MAX_MIN_DEF,
  parameter int MAX_SEC  = MAX_SEC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_clear,
  input  logic             btn_min_inc,
  input  logic             btn_sec_inc,
  output logic [VAL_W-1:0] min_out,
  output logic [VAL_W-1:0] sec_out,
  output logic             running,
  output logic             done,
  output logic             tick_en
);

  localparam logic [VAL_W-1:0] MIN_TOP = VAL_W'(MAX_MIN);
  localparam logic [VAL_W-1:0] SEC_TOP = VAL_W'(MAX_SEC);

  state_t           state, state_n;
  logic [VAL_W-1:0] min_n, sec_n;
  logic             tick_n;
  logic             pre_en, pre_clr, tick;
  logic             nonzero, editable;

  timer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign nonzero  = (min_out != '0) || (sec_out != '0);
  assign editable = (state == ST_IDLE) || (state == ST_SET) || (state == ST_PAUSE);

  always_comb begin
    state_n = state;
    min_n   = min_out;
    sec_n   = sec_out;
    tick_n  = 1'b0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    if (btn_clear) begin
      state_n = ST_IDLE;
      min_n   = '0;
      sec_n   = '0;
      pre_clr = 1'b1;
    end else if (btn_start) begin
      // Start in RUN leaves pre_en low, so a coinciding tick is swallowed.
      case (state)
        ST_SET: begin
          if (nonzero) begin
            state_n = ST_RUN;
            pre_clr = 1'b1;
          end
        end
        ST_PAUSE: if (nonzero) state_n = ST_RUN;
        ST_RUN:   state_n = ST_PAUSE;
        ST_DONE: begin
          state_n = ST_IDLE;
          min_n   = '0;
          sec_n   = '0;
        end
        default: ;
      endcase
    end else if (state == ST_RUN) begin
      pre_en = 1'b1;
      if (tick) begin
        tick_n = 1'b1;
        if (sec_out != '0) begin
          sec_n = sec_out - 1'b1;
        end else if (min_out != '0) begin
          min_n = min_out - 1'b1;
          sec_n = SEC_TOP;
        end
        if ((min_n == '0) && (sec_n == '0)) state_n = ST_DONE;
      end
    end else if (editable && (btn_min_inc || btn_sec_inc)) begin
      if (btn_min_inc) min_n = (min_out >= MIN_TOP) ? '0 : min_out + 1'b1;
      else             sec_n = (sec_out >= SEC_TOP) ? '0 : sec_out + 1'b1;
      if (state == ST_IDLE) state_n = ST_SET;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      min_out <= '0;
      sec_out <= '0;
      tick_en <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      min_out <= min_n;
      sec_out <= sec_n;
      tick_en <= tick_n;
      running <= (state_n == ST_RUN);
      done    <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_timer_min_sec_ctrl.sv
// tb/tb_timer_min_sec_ctrl.sv - randomized and directed checks of the min:sec countdown timer
module tb_timer_min_sec_ctrl;

  localparam int TD = 10;
  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_clear = 1'b0, btn_min_inc = 1'b0, btn_sec_inc = 1'b0;
  logic [5:0] min_out, sec_out;
  logic       running, done, tick_en;

  int total = 0;
  int bad = 0;

  int mode = M_IDLE, mm = 0, ms = 0, ph = 0;
  bit tk = 0;

  timer_min_sec_ctrl #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .btn_min_inc (btn_min_inc),
    .btn_sec_inc (btn_sec_inc),
    .min_out     (min_out),
    .sec_out     (sec_out),
    .running     (running),
    .done        (done),
    .tick_en     (tick_en)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] got();
    return {min_out, sec_out, running, done, tick_en};
  endfunction

  function automatic logic [14:0] want();
    return {6'(mm), 6'(ms), mode == M_RUN, mode == M_DONE, tk};
  endfunction

  task automatic model_reset();
    mode = M_IDLE; mm = 0; ms = 0; ph = 0; tk = 0;
  endtask

  // Remaining time handled as plain seconds: borrow reload of 59 is base-60 arithmetic.
  task automatic model_step(input bit c, input bit st, input bit mi, input bit si);
    int rem;
    tk = 0;
    if (c) begin
      mode = M_IDLE; mm = 0; ms = 0; ph = 0;
    end else if (st) begin
      if ((mode == M_SET || mode == M_PAUSE) && (mm + ms) > 0) begin
        if (mode == M_SET) ph = 0;
        mode = M_RUN;
      end else if (mode == M_RUN) mode = M_PAUSE;
      else if (mode == M_DONE) begin mode = M_IDLE; mm = 0; ms = 0; end
    end else if (mode == M_RUN) begin
      if (ph == TD - 1) begin
        ph = 0;
        rem = mm * 60 + ms - 1;
        mm = rem / 60; ms = rem % 60; tk = 1;
        if (rem == 0) mode = M_DONE;
      end else ph++;
    end else if (mode != M_DONE && (mi || si)) begin
      if (mi) mm = (mm + 1) % 60; else ms = (ms + 1) % 60;
      if (mode == M_IDLE) mode = M_SET;
    end
  endtask

  task automatic step(input bit c, input bit st, input bit mi, input bit si);
    btn_clear = c; btn_start = st; btn_min_inc = mi; btn_sec_inc = si;
    @(posedge clk);
    model_step(c, st, mi, si);
    #1;
    btn_clear = 0; btn_start = 0; btn_min_inc = 0; btn_sec_inc = 0;
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0);
      total++;
      if (got() !== want()) begin
        bad++;
        $display("FAIL %s cyc%0d got=%h want=%h", name, i, got(), want());
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (got() !== 15'h0) begin bad++; $display("FAIL reset got=%h want=0", got()); end
    rst = 0;
    step(0, 0, 0, 0);
    total++;
    if (got() !== 15'h0) begin bad++; $display("FAIL reset_release got=%h want=0", got()); end
  endtask

  task automatic test_preset_run();
    int pulses = 0;
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    total++;
    if (got() !== {6'd1, 6'd3, 3'b000}) begin bad++; $display("FAIL preset got=%h want=%h", got(), {6'd1, 6'd3, 3'b000}); end
    step(0, 1, 0, 0);
    for (int i = 0; i < 4 * TD; i++) begin
      step(0, 0, 0, 0);
      pulses += int'(tick_en);
      total++;
      if (got() !== want()) begin bad++; $display("FAIL run cyc%0d got=%h want=%h", i, got(), want()); end
    end
    total++;
    if (got() !== {6'd0, 6'd59, 3'b101}) begin bad++; $display("FAIL run_0059 got=%h want=%h", got(), {6'd0, 6'd59, 3'b101}); end
    total++;
    if (pulses != 4) begin bad++; $display("FAIL tick_count got=%0d want=4", pulses); end
  endtask

  task automatic test_expire();
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle_check(2 * TD, "expire");
    total++;
    if (got() !== {12'd0, 3'b011}) begin bad++; $display("FAIL done_state got=%h want=%h", got(), {12'd0, 3'b011}); end
    idle_check(5, "done_hold");
    step(0, 1, 0, 0);
    total++;
    if (got() !== 15'h0) begin bad++; $display("FAIL done_exit got=%h want=0", got()); end
  endtask

  task automatic test_pause_resume();
    int lat = -1;
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    idle_check(30, "paused");
    total++;
    if (got() !== {6'd0, 6'd5, 3'b000}) begin bad++; $display("FAIL pause_hold got=%h want=%h", got(), {6'd0, 6'd5, 3'b000}); end
    step(0, 1, 0, 0);
    for (int i = 1; i <= 2 * TD && lat < 0; i++) begin
      step(0, 0, 0, 0);
      if (tick_en) lat = i;
    end
    total++;
    if (lat != 6 || sec_out !== 6'd4) begin bad++; $display("FAIL resume_latency got=%0d/%0d want=6/4", lat, sec_out); end
  endtask

  task automatic preset_2_30_run_to_edge();
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (30) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int g = 0; g < 2 * TD && ph != TD - 1; g++) step(0, 0, 0, 0);
  endtask

  task automatic test_coincide();
    preset_2_30_run_to_edge();
    step(1, 1, 0, 0);
    total++;
    if (got() !== 15'h0) begin bad++; $display("FAIL clear_start got=%h want=0", got()); end
    preset_2_30_run_to_edge();
    step(0, 1, 0, 0);
    total++;
    if (got() !== {6'd2, 6'd30, 3'b000}) begin bad++; $display("FAIL start_tick got=%h want=%h", got(), {6'd2, 6'd30, 3'b000}); end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    total++;
    if (got() !== {6'd2, 6'd29, 3'b101}) begin bad++; $display("FAIL resume_tick got=%h want=%h", got(), {6'd2, 6'd29, 3'b101}); end
  endtask

  task automatic test_wrap();
    step(1, 0, 0, 0);
    repeat (60) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    total++;
    if (got() !== 15'h0) begin bad++; $display("FAIL sec_wrap got=%h want=0", got()); end
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    total++;
    if (got() !== {6'd0, 6'd59, 3'b101} && min_out !== 6'd1) begin bad++; $display("FAIL inc_in_run got=%h", got()); end
    total++;
    if (got() !== want()) begin bad++; $display("FAIL inc_in_run_model got=%h want=%h", got(), want()); end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    #2 rst = 1;
    #1;
    model_reset();
    total++;
    if (got() !== 15'h0) begin bad++; $display("FAIL async_reset got=%h want=0", got()); end
    @(posedge clk);
    #1 rst = 0;
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    idle_check(TD + 2, "after_reset");
  endtask

  task automatic test_random();
    bit c, st, mi, si;
    for (int i = 0; i < 1500; i++) begin
      c  = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 24) == 0);
      mi = ($urandom_range(0, 9) == 0);
      si = ($urandom_range(0, 4) == 0);
      step(c, st, mi, si);
      total++;
      if (got() !== want()) begin bad++; $display("FAIL random cyc%0d got=%h want=%h", i, got(), want()); end
    end
  endtask

  initial begin
    test_reset();
    test_preset_run();
    test_expire();
    test_pause_resume();
    test_coincide();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_min_sec_ctrl.md
Name: timer_min_sec_ctrl

Overview:
- Countdown-timer controller for the min:sec timer.
- Owns the tick prescaler and sequences it with a run/pause/done state machine.
- Lets the user preset minutes/seconds and emits a BCD-ready binary min/sec value to the FND display path.
- Sits between the debounced button pulses and the display formatter.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1-second tick (sim uses 10)
MAX_MIN, 59, highest presettable minute value
MAX_SEC, 59, highest second value (also reload value on minute borrow)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_start  input  1  1-cycle pulse; start/pause toggle
btn_clear  input  1  1-cycle pulse; abort and zero
btn_min_inc  input  1  1-cycle pulse; +1 minute in preset
btn_sec_inc  input  1  1-cycle pulse; +1 second in preset
min_out  output  6  current minutes, 0..MAX_MIN
sec_out  output  6  current seconds, 0..MAX_SEC
running  output  1  high in RUN
done  output  1  high in DONE
tick_en  output  1  1-cycle pulse on every decrement (for blink/LED logic)

Behaviour:
- Interface: single clock clk; rst asynchronous, active-high.
- Reset values:
  - state=IDLE, min_out=0, sec_out=0, prescaler=0.
  - running=0, done=0, tick_en=0.
- States:
  - IDLE: value 00:00; inc buttons load the value and go to SET.
  - SET: preset editing.
  - RUN: counting down.
  - PAUSE: frozen.
  - DONE: reached 00:00 by counting.
- Button priority when pulses coincide: btn_clear > btn_start > btn_min_inc > btn_sec_inc. Only the highest-priority pulse acts.
- btn_clear, any state:
  - Next cycle: IDLE, min=sec=0, prescaler=0.
  - A tick coinciding with clear is discarded.
- btn_min_inc / btn_sec_inc:
  - Honoured only in IDLE/SET/PAUSE. PAUSE stays PAUSE, which allows adjusting while paused. IDLE goes to SET.
  - Value increments; MAX wraps to 0. No carry between sec and min.
  - Ignored in RUN and DONE.
- btn_start:
  - SET/PAUSE with value != 00:00 → RUN.
  - SET with 00:00 → ignored; stay SET.
  - RUN → PAUSE.
  - IDLE → ignored.
  - DONE → IDLE, value 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds in PAUSE.
  - Zeroed on entry to RUN from SET, and on clear.
  - Resumes from the held count on PAUSE→RUN.
  - Wraps to 0 at TICK_DIV-1, generating tick.
- tick_en: registered; asserted the cycle the decremented value appears on outputs. First decrement occurs TICK_DIV cycles after the RUN-entry cycle.
- Decrement on tick:
  - sec>0: sec-1.
  - sec=0, min>0: min-1, sec=MAX_SEC.
  - Result 00:00 → state DONE the same cycle the value becomes 00:00. done=1, running=0, prescaler stops.
- btn_start coinciding with tick in RUN: pause wins, no decrement. Prescaler holds at TICK_DIV-1, so a tick fires on the first RUN cycle after resume.
- Outputs running/done are registered decodes of state. min_out/sec_out are registers, never exceeding MAX.
- Prescaler width: $clog2(TICK_DIV); values 6-bit unsigned.
- Reset mid-RUN: immediate async return to reset values.

Decomposition:
- Shared timer package:
  - State encoding localparams: IDLE, SET, RUN, PAUSE, DONE.
  - MAX_MIN / MAX_SEC defaults.
- One sub-module: timer_tick_gen.
  - Parameterised prescaler with en, clr, tick out.
  - Generalisation of the existing fixed 10k counter, with enable and synchronous clear added.
- FSM and min/sec registers stay in timer_min_sec_ctrl.

Test Plan (TICK_DIV=10):
1. Reset, 3×btn_sec_inc, 1×btn_min_inc, btn_start → SET at 01:03. RUN; 00:59 after 4 ticks. tick_en pulses every 10 cycles. running=1.
2. Preset 00:02, start, wait 20 cycles → 00:01 then 00:00. done=1, running=0, state DONE. Further cycles: no change. btn_start → IDLE, 00:00, done=0.
3. RUN at 00:05, btn_start after 4 cycles → PAUSE, value held 30 cycles. btn_start → first tick 6 cycles later (resumed prescaler), value 00:04.
4. Simultaneous btn_clear+btn_start in RUN at 02:30 → IDLE, 00:00, running=0, no tick. Simultaneous btn_start+tick → PAUSE, value unchanged.
5. 60×btn_sec_inc from IDLE → sec wraps to 0, min stays 0. btn_start in SET at 00:00 → ignored, stays SET. btn_min_inc during RUN → ignored.
6. Assert rst for 1 cycle mid-RUN at 10:00 → all outputs 0 immediately (asynchronous). Operation resumes normally after deassert.
